pc_update: RTL and testbench

Program-counter update stage of the single-cycle (SEQ) Y86-64 processor. Each clock it selects the next PC from the fetch (`valP`), decode/fetch constant (`valC`) or memory (`valM`) values according to the current instruction code and branch condition, and registers it as the PC driven back to fetch. It sits after the memory stage and closes the SEQ loop.

---
 rtl/pc_update.sv | 87 ++++++++
 tb/tb_pc_update.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pc_update.sv
// pc_update: SEQ Y86-64 program-counter update stage.
// Selects the next PC from valP/valC/valM by icode and branch condition and
// registers it as updatedPC.
// Build option PC_UPDATE_HALT_EN: when defined, a retired halt or an invalid
// icode freezes the PC until reset and raises the sticky halted/instr_err
// flags. When undefined, the flags read 0, halt behaves like nop and an
// invalid icode holds the PC for that one cycle only.
module pc_update #(
   parameter logic [63:0] RESET_PC = 64'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  icode,
   input  logic        cnd,
   input  logic [63:0] valC,
   input  logic [63:0] valM,
   input  logic [63:0] valP,
   output logic [63:0] next_pc,
   output logic [63:0] updatedPC,
   output logic        halted,
   output logic        instr_err
);

   localparam logic [3:0] I_HALT = 4'h0;
   localparam logic [3:0] I_JXX  = 4'h7;
   localparam logic [3:0] I_CALL = 4'h8;
   localparam logic [3:0] I_RET  = 4'h9;

   logic [63:0] pc_q;
   logic        invalid;

   assign invalid   = (icode >= 4'hC);
   assign updatedPC = pc_q;

   // Next-PC selection; cnd matters only for jXX, invalid icodes hold the PC
   always_comb begin
      next_pc = valP;
      case (icode)
         I_JXX:   next_pc = cnd ? valC : valP;
         I_CALL:  next_pc = valC;
         I_RET:   next_pc = valM;
         4'hC, 4'hD, 4'hE, 4'hF: next_pc = pc_q;
         default: next_pc = valP;
      endcase
   end

`ifdef PC_UPDATE_HALT_EN
   logic halted_q;
   logic err_q;
   logic frozen;

   assign frozen    = halted_q | err_q;
   assign halted    = halted_q;
   assign instr_err = err_q;

   // PC register plus sticky flags; once frozen only reset restarts the PC,
   // but an invalid icode still records the error
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (!frozen) begin
            pc_q <= next_pc;
            if (icode == I_HALT)
               halted_q <= 1'b1;
         end
         if (invalid)
            err_q <= 1'b1;
      end
   end
`else
   assign halted    = 1'b0;
   assign instr_err = 1'b0;

   // PC register; invalid icodes already select the current PC, so they
   // hold for exactly one cycle
   always_ff @(posedge clk) begin
      if (reset)
         pc_q <= RESET_PC;
      else
         pc_q <= next_pc;
   end
`endif

endmodule

// File: tb/tb_pc_update.sv
// tb_pc_update: directed vectors for pc_update with a queue-based scoreboard.
// The driver pushes the expected registered state for each cycle it issues;
// a monitor pops and compares one entry just after every rising edge.
module tb_pc_update;

`ifdef PC_UPDATE_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  icode;
   logic        cnd;
   logic [63:0] valC, valM, valP;
   logic [63:0] next_pc, updatedPC;
   logic        halted, instr_err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [63:0] pc;
      logic        h;
      logic        e;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   pc_update #(.RESET_PC(64'd0)) dut (
      .clk(clk), .reset(reset), .icode(icode), .cnd(cnd),
      .valC(valC), .valM(valM), .valP(valP),
      .next_pc(next_pc), .updatedPC(updatedPC),
      .halted(halted), .instr_err(instr_err)
   );

   always #5 clk = ~clk;

   // Monitor: after each edge compare registered outputs with the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (updatedPC !== e.pc || halted !== e.h || instr_err !== e.e) begin
               n_fail++;
               $display("FAIL %s: got pc=%0h halted=%b err=%b, expected pc=%0h halted=%b err=%b",
                        e.name, updatedPC, halted, instr_err, e.pc, e.h, e.e);
            end
         end
      end
   end

   // Drive one cycle of inputs, check next_pc, queue the post-edge expectation
   task automatic step(input logic rst, input logic [3:0] ic, input logic c,
                       input logic [63:0] vc, input logic [63:0] vm, input logic [63:0] vp,
                       input bit chk_next, input logic [63:0] exp_next,
                       input logic [63:0] exp_pc, input logic exp_h, input logic exp_e,
                       input string nm);
      exp_t e;
      @(negedge clk);
      reset = rst; icode = ic; cnd = c; valC = vc; valM = vm; valP = vp;
      #1;
      if (chk_next) begin
         n_checks++;
         if (next_pc !== exp_next) begin
            n_fail++;
            $display("FAIL %s next_pc: got %0h, expected %0h", nm, next_pc, exp_next);
         end
      end
      e.pc = exp_pc; e.h = exp_h; e.e = exp_e; e.name = nm;
      exp_q.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, queue depth %0d expected 0", exp_q.size());
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; icode = 4'h1; cnd = 1'b0; valC = '0; valM = '0; valP = '0;

      //   rst ic    cnd  valC  valM  valP  chk next  pc  h  e
      step(1, 4'h1, 0,   0,    0,    0,    0,  0,    0,  0, 0, "reset");
      step(0, 4'h1, 0,   0,    0,    2,    1,  2,    2,  0, 0, "nop");
      step(0, 4'h2, 1,   9,    9,    4,    1,  4,    4,  0, 0, "cmov");
      step(0, 4'h3, 1,   9,    9,   14,    1, 14,   14,  0, 0, "irmovq");
      step(0, 4'h4, 0,   9,    9,   24,    1, 24,   24,  0, 0, "rmmovq");
      step(0, 4'h5, 0,   9,    9,   34,    1, 34,   34,  0, 0, "mrmovq");
      step(0, 4'h6, 1,   9,    9,   36,    1, 36,   36,  0, 0, "opq");
      step(0, 4'hF, 0,   9,    9,  300,    1, 36,   36,  0, HALT_EN, "invalid_f");
      step(0, 4'h1, 0,   0,    0,   40,    1, 40,   HALT_EN ? 64'd36 : 64'd40, 0, HALT_EN, "nop_after_err");
      step(1, 4'h8, 0,  77,   77,   77,    0,  0,    0,  0, 0, "reset2");
      step(0, 4'h7, 0,  50,    0,   45,    1, 45,   45,  0, 0, "jxx_not_taken");
      step(0, 4'h7, 1, 100,    0,   56,    1, 100, 100,  0, 0, "jxx_taken");
      step(0, 4'h8, 0, 150,    0,  109,    1, 150, 150,  0, 0, "call");
      step(0, 4'h9, 0, 150,  109,  151,    1, 109, 109,  0, 0, "ret");
      step(0, 4'hA, 1, 999,  999,  111,    1, 111, 111,  0, 0, "pushq");
      step(0, 4'hB, 1, 999,  999,  113,    1, 113, 113,  0, 0, "popq");
      step(0, 4'h0, 0, 999,  999,  114,    1, 114, 114,  HALT_EN, 0, "halt");
      step(0, 4'h1, 0,   0,    0,  200,    1, 200,  HALT_EN ? 64'd114 : 64'd200, HALT_EN, 0, "nop_after_halt");
      step(0, 4'hE, 0,   0,    0,  300,    1, HALT_EN ? 64'd114 : 64'd200,
           HALT_EN ? 64'd114 : 64'd200, HALT_EN, HALT_EN, "invalid_while_halted");
      step(1, 4'h1, 0,   0,    0,  500,    0,  0,    0,  0, 0, "reset3");
      step(0, 4'h9, 1,   7,    8,    9,    1,  8,    8,  0, 0, "ret_ignores_cnd");
      step(0, 4'h7, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 64'h10, 1, 64'hFFFF_FFFF_FFFF_FFF8,
           64'hFFFF_FFFF_FFFF_FFF8, 0, 0, "jxx_wide");
      step(0, 4'h4, 1, 64'hAAAA_0000_0000_0001, 0, 64'h8000_0000_0000_0003, 1,
           64'h8000_0000_0000_0003, 64'h8000_0000_0000_0003, 0, 0, "rmmovq_cnd_ignored");
      step(0, 4'h1, 0,   0,    0,    5,    1,  5,    5,  0, 0, "nop_final");

      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
